// File: rtl/apb_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// apb_gpio_ctrl
//
// APB slave GPIO controller. Holds the pad direction and output registers,
// synchronises the asynchronous pad inputs and latches enabled rising/falling
// edges into sticky status bits. The interrupt is a level: the OR of STATUS.
//
// Register map (byte offsets, PADDR[11:0]):
//   0x00 DIR      RW    1 = pin driven
//   0x04 OUT      RW    pad output values
//   0x08 IN       RO    synchronised pad inputs
//   0x0C RISE_EN  RW    rising-edge capture enable
//   0x10 FALL_EN  RW    falling-edge capture enable
//   0x14 STATUS   RW1C  sticky edge flags
//   0x18 OUT_SET  WO    OUT |= PWDATA
//   0x1C OUT_CLR  WO    OUT &= ~PWDATA
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   PADDR..PWDATA       APB requester inputs
//   PRDATA, PREADY,     APB completer outputs
//   PSLVERR
//   gpio_i              asynchronous pad inputs
//   gpio_o, gpio_oe     registered pad output values / output enables
//   irq                 level interrupt, high while any STATUS bit is set
//
// Handshake: a transfer is accepted when PSEL & PENABLE & PREADY is high at a
// rising clock edge; that edge is the only point where register state changes.
// PREADY is high for the whole access phase (zero wait states) and low
// otherwise. PRDATA/PSLVERR are meaningful only while PREADY is high and are
// held at 0 at all other times.
// ---------------------------------------------------------------------------
module apb_gpio_ctrl #(
  parameter int NUM_GPIO    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [11:0]         PADDR,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  localparam logic [2:0]  IDX_DIR     = 3'd0;
  localparam logic [2:0]  IDX_OUT     = 3'd1;
  localparam logic [2:0]  IDX_IN      = 3'd2;
  localparam logic [2:0]  IDX_RISE_EN = 3'd3;
  localparam logic [2:0]  IDX_FALL_EN = 3'd4;
  localparam logic [2:0]  IDX_STATUS  = 3'd5;
  localparam logic [2:0]  IDX_OUT_SET = 3'd6;
  localparam logic [2:0]  IDX_OUT_CLR = 3'd7;
  localparam logic [11:0] LAST_OFF    = 12'h01C;

  logic [NUM_GPIO-1:0] dir_q;
  logic [NUM_GPIO-1:0] out_q;
  logic [NUM_GPIO-1:0] rise_en_q;
  logic [NUM_GPIO-1:0] fall_en_q;
  logic [NUM_GPIO-1:0] status_q;
  logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_GPIO-1:0] prev_q;

  logic                access;
  logic [2:0]          reg_idx;
  logic                acc_err;
  logic                wr_en;
  logic [NUM_GPIO-1:0] wdata;
  logic [NUM_GPIO-1:0] sync_in;
  logic [NUM_GPIO-1:0] rise;
  logic [NUM_GPIO-1:0] fall;
  logic [NUM_GPIO-1:0] w1c_mask;
  logic [NUM_GPIO-1:0] rd_val;
  logic [31:0]         rd_ext;
  logic                unused_pwdata;

  // PWDATA bits at and above NUM_GPIO have no storage behind them; they are
  // folded into this reduction only so every input bit has a load.
  assign unused_pwdata = ^PWDATA;

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  assign access  = PSEL & PENABLE;
  assign reg_idx = PADDR[4:2];
  assign wdata   = PWDATA[NUM_GPIO-1:0];

  // Misaligned, out-of-map, write-to-RO and read-of-WO accesses all error
  // and are not allowed to touch any register.
  assign acc_err = (PADDR[1:0] != 2'b00) || (PADDR > LAST_OFF) ||
                   (PWRITE  && (reg_idx == IDX_IN)) ||
                   (!PWRITE && ((reg_idx == IDX_OUT_SET) || (reg_idx == IDX_OUT_CLR)));

  assign wr_en = access & PWRITE & ~acc_err;

  // ------------------------------------------------------------------
  // APB response; gated by reset_n so every response output is 0 in reset
  // ------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      IDX_DIR:     rd_val = dir_q;
      IDX_OUT:     rd_val = out_q;
      IDX_IN:      rd_val = sync_in;
      IDX_RISE_EN: rd_val = rise_en_q;
      IDX_FALL_EN: rd_val = fall_en_q;
      IDX_STATUS:  rd_val = status_q;
      default:     rd_val = '0;
    endcase
    rd_ext                 = '0;
    rd_ext[NUM_GPIO-1:0]   = rd_val;
  end

  assign PREADY  = access & reset_n;
  assign PSLVERR = access & reset_n & acc_err;
  assign PRDATA  = (access && reset_n && !PWRITE && !acc_err) ? rd_ext : 32'h0;

  // ------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_q & rise_en_q;
  assign fall    = ~sync_in & prev_q & fall_en_q;

  // ------------------------------------------------------------------
  // Control registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        IDX_DIR:     dir_q     <= wdata;
        IDX_OUT:     out_q     <= wdata;
        IDX_RISE_EN: rise_en_q <= wdata;
        IDX_FALL_EN: fall_en_q <= wdata;
        IDX_OUT_SET: out_q     <= out_q | wdata;
        IDX_OUT_CLR: out_q     <= out_q & ~wdata;
        default:     ;
      endcase
    end
  end

  // Sticky status: the new edge terms are OR-ed in after the clear, so an
  // edge arriving together with a W1C of the same bit keeps the bit set.
  assign w1c_mask = (wr_en && (reg_idx == IDX_STATUS)) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status_q <= '0;
    else          status_q <= (status_q & ~w1c_mask) | rise | fall;
  end

  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq     = |status_q;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
module tb_apb_gpio_ctrl;

  localparam int N = 8;

  localparam logic [11:0] A_DIR     = 12'h000;
  localparam logic [11:0] A_OUT     = 12'h004;
  localparam logic [11:0] A_IN      = 12'h008;
  localparam logic [11:0] A_RISE_EN = 12'h00C;
  localparam logic [11:0] A_FALL_EN = 12'h010;
  localparam logic [11:0] A_STATUS  = 12'h014;
  localparam logic [11:0] A_OUT_SET = 12'h018;
  localparam logic [11:0] A_OUT_CLR = 12'h01C;

  logic          clk;
  logic          reset_n;
  logic [11:0]   PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [N-1:0]  gpio_i;
  logic [N-1:0]  gpio_o;
  logic [N-1:0]  gpio_oe;
  logic          irq;

  int checks;
  int failures;

  // Expected APB response per access: {pslverr, prdata}
  logic [32:0] exp_q[$];

  apb_gpio_ctrl #(.NUM_GPIO(N), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
    @(posedge clk); #1;
    PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    exp_q.push_back({exp_err, wr ? 32'h0 : exp_rdata});
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, input logic exp_err);
    apb_xfer(addr, 1'b1, data, 32'h0, exp_err);
  endtask

  task automatic apb_read(input logic [11:0] addr, input logic [31:0] exp_data, input logic exp_err);
    apb_xfer(addr, 1'b0, 32'h0, exp_data, exp_err);
  endtask

  task automatic check_pins(input string name, input logic [N-1:0] exp_o,
                            input logic [N-1:0] exp_oe, input logic exp_irq);
    check({name, "_gpio_o"},  {24'h0, gpio_o},  {24'h0, exp_o});
    check({name, "_gpio_oe"}, {24'h0, gpio_oe}, {24'h0, exp_oe});
    check({name, "_irq"},     {31'h0, irq},     {31'h0, exp_irq});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (PSEL && PENABLE) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL apb_unexpected_access actual=1 expected=0 @%0t", $time);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("apb_pready",  {31'h0, PREADY},  32'h1);
          check("apb_pslverr", {31'h0, PSLVERR}, {31'h0, e[32]});
          check("apb_prdata",  PRDATA,           e[31:0]);
        end
      end else begin
        check("apb_idle", PRDATA | {30'h0, PREADY, PSLVERR}, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
    gpio_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check_pins("reset", 8'h00, 8'h00, 1'b0);
    check("reset_apb", PRDATA | {30'h0, PREADY, PSLVERR}, 32'h0);
    reset_n = 1'b1;

    // 1: direction and output
    apb_write(A_DIR, 32'h0000_00FF, 1'b0);
    check_pins("t1_dir", 8'h00, 8'hFF, 1'b0);
    apb_write(A_OUT, 32'h0000_00A5, 1'b0);
    check_pins("t1_out", 8'hA5, 8'hFF, 1'b0);
    apb_read(A_OUT, 32'h0000_00A5, 1'b0);
    apb_read(A_DIR, 32'h0000_00FF, 1'b0);

    // 2: set / clear aliases
    apb_write(A_OUT, 32'h0000_00F0, 1'b0);
    check_pins("t2_out", 8'hF0, 8'hFF, 1'b0);
    apb_write(A_OUT_SET, 32'h0000_0003, 1'b0);
    check_pins("t2_set", 8'hF3, 8'hFF, 1'b0);
    apb_write(A_OUT_CLR, 32'h0000_0010, 1'b0);
    check_pins("t2_clr", 8'hE3, 8'hFF, 1'b0);
    apb_read(A_OUT_SET, 32'h0, 1'b1);
    apb_read(A_OUT_CLR, 32'h0, 1'b1);
    apb_read(A_OUT, 32'h0000_00E3, 1'b0);

    // 3: rising edge on pin 0
    apb_write(A_RISE_EN, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    gpio_i[0] = 1'b1;
    @(posedge clk); #1;
    check("t3_irq_edge1", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("t3_irq_edge2", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("t3_irq_edge3", {31'h0, irq}, 32'h1);
    apb_read(A_IN, 32'h0000_0001, 1'b0);
    apb_read(A_STATUS, 32'h0000_0001, 1'b0);
    apb_write(A_STATUS, 32'h0000_0001, 1'b0);
    check("t3_irq_cleared", {31'h0, irq}, 32'h0);
    apb_read(A_STATUS, 32'h0, 1'b0);

    // 4: falling edge on pin 2 coincident with its W1C
    gpio_i[2] = 1'b1;
    repeat (4) @(posedge clk);
    apb_write(A_FALL_EN, 32'h0000_0004, 1'b0);
    apb_read(A_STATUS, 32'h0, 1'b0);
    apb_read(A_IN, 32'h0000_0005, 1'b0);
    @(posedge clk); #1;
    gpio_i[2] = 1'b0;
    apb_write(A_STATUS, 32'h0000_0004, 1'b0);
    check("t4_irq_set_wins", {31'h0, irq}, 32'h1);
    apb_read(A_STATUS, 32'h0000_0004, 1'b0);
    apb_write(A_STATUS, 32'h0000_0004, 1'b0);
    check("t4_irq_cleared", {31'h0, irq}, 32'h0);

    // 5: error cases leave state untouched
    apb_read(12'h020, 32'h0, 1'b1);
    apb_write(12'h020, 32'h0, 1'b1);
    apb_write(A_IN, 32'h0000_00FF, 1'b1);
    apb_write(12'h006, 32'h0, 1'b1);
    apb_read(12'h006, 32'h0, 1'b1);
    apb_write(12'h016, 32'h0000_00FF, 1'b1);
    check_pins("t5_after_err", 8'hE3, 8'hFF, 1'b0);
    apb_read(A_DIR, 32'h0000_00FF, 1'b0);
    apb_read(A_OUT, 32'h0000_00E3, 1'b0);
    apb_read(A_RISE_EN, 32'h0000_0001, 1'b0);

    // 6: reset during the access phase of a DIR write
    apb_write(A_DIR, 32'h0000_0000, 1'b0);
    check_pins("t6_pre", 8'hE3, 8'h00, 1'b0);
    @(posedge clk); #1;
    PADDR = A_DIR; PWRITE = 1'b1; PWDATA = 32'h0000_00FF; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_pins("t6_in_reset", 8'h00, 8'h00, 1'b0);
    check("t6_apb_in_reset", PRDATA | {30'h0, PREADY, PSLVERR}, 32'h0);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_pins("t6_released", 8'h00, 8'h00, 1'b0);
    apb_write(A_DIR, 32'h0000_000F, 1'b0);
    check_pins("t6_first_access", 8'h00, 8'h0F, 1'b0);
    apb_read(A_DIR, 32'h0000_000F, 1'b0);
    apb_read(A_STATUS, 32'h0, 1'b0);
    apb_read(A_IN, 32'h0000_0001, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
